// File: rtl/l2_playback_replay_if.sv
// Load/replay/result signal bundle for the L2 vector-replay engine.
// L2_PLAYBACK_MASK_EN adds the per-bit compare mask to the load channel.
interface l2_playback_replay_if #(
  parameter int IN_W   = 170,
  parameter int OUT_W  = 71,
  parameter int ADDR_W = 8
);
  logic              clear;
  logic              load_valid;
  logic              load_ready;
  logic [IN_W-1:0]   load_in_vec;
  logic [OUT_W-1:0]  load_out_vec;
`ifdef L2_PLAYBACK_MASK_EN
  logic [OUT_W-1:0]  load_out_mask;
`endif
  logic              start;
  logic              busy;
  logic              done;
  logic [IN_W-1:0]   dut_in_vec;
  logic [OUT_W-1:0]  dut_out_vec;
  logic [15:0]       mismatch_cnt;
  logic              first_mis_valid;
  logic [ADDR_W-1:0] first_mis_idx;

`ifdef L2_PLAYBACK_MASK_EN
  modport master (
    output clear, load_valid, load_in_vec, load_out_vec, load_out_mask, start, dut_out_vec,
    input  load_ready, busy, done, dut_in_vec, mismatch_cnt, first_mis_valid, first_mis_idx
  );
  modport slave (
    input  clear, load_valid, load_in_vec, load_out_vec, load_out_mask, start, dut_out_vec,
    output load_ready, busy, done, dut_in_vec, mismatch_cnt, first_mis_valid, first_mis_idx
  );
`else
  modport master (
    output clear, load_valid, load_in_vec, load_out_vec, start, dut_out_vec,
    input  load_ready, busy, done, dut_in_vec, mismatch_cnt, first_mis_valid, first_mis_idx
  );
  modport slave (
    input  clear, load_valid, load_in_vec, load_out_vec, start, dut_out_vec,
    output load_ready, busy, done, dut_in_vec, mismatch_cnt, first_mis_valid, first_mis_idx
  );
`endif
endinterface

// File: rtl/l2_playback_replay.sv
// Vector-replay engine: stores L2 stimulus/response pairs, replays them one per clock and
// counts response mismatches. Optional feature macro: L2_PLAYBACK_MASK_EN (per-bit compare mask).
module l2_playback_replay #(
  parameter int IN_W   = 170,
  parameter int OUT_W  = 71,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l2_playback_replay_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [ADDR_W-1:0] idx_p0_q, idx_p0_d, idx_p1_q, idx_p1_d;
  logic [IN_W-1:0]   dut_in_vec_q, dut_in_vec_d;
  logic [15:0]       mis_cnt_q, mis_cnt_d;
  logic              first_vld_q, first_vld_d;
  logic [ADDR_W-1:0] first_idx_q, first_idx_d;
  logic              busy_q, busy_d, done_q, done_d, load_ready_q, load_ready_d;

  logic [IN_W-1:0]   mem_in  [DEPTH];
  logic [OUT_W-1:0]  mem_out [DEPTH];
  logic [IN_W-1:0]   rd_in_p0_q, rd_in_p0_d;
  logic [OUT_W-1:0]  rd_out_p0_q, rd_out_p0_d, exp_p1_q;
  logic [OUT_W-1:0]  diff;

  logic load_fire, start_acc, issue, last_issue, mis;

  assign load_fire  = bus.load_valid & load_ready_q & ~bus.clear;
  // A load in the same cycle as start counts toward the run length.
  assign start_acc  = bus.start & ~bus.clear &
                      (((state_q == IDLE) & ((count_q != '0) | load_fire)) | (state_q == DONE));
  assign issue      = (state_q == RUN);
  assign last_issue = issue & ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));

`ifdef L2_PLAYBACK_MASK_EN
  logic [OUT_W-1:0] mem_mask [DEPTH];
  logic [OUT_W-1:0] rd_mask_p0_q, rd_mask_p0_d, mask_p1_q;
  assign rd_mask_p0_d = mem_mask[rd_ptr_q];
  assign diff = (bus.dut_out_vec ^ exp_p1_q) & mask_p1_q;
  always_ff @(posedge clk) begin
    if (load_fire) mem_mask[wr_ptr_q] <= bus.load_out_mask;
    rd_mask_p0_q <= rd_mask_p0_d;
    mask_p1_q    <= rd_mask_p0_q;
  end
`else
  assign diff = bus.dut_out_vec ^ exp_p1_q;
`endif

  assign mis         = vld_p1_q & (|diff);
  assign rd_in_p0_d  = mem_in[rd_ptr_q];
  assign rd_out_p0_d = mem_out[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    vld_p0_d     = issue;
    idx_p0_d     = rd_ptr_q;
    vld_p1_d     = vld_p0_q;
    idx_p1_d     = idx_p0_q;
    dut_in_vec_d = vld_p0_q ? rd_in_p0_q : '0;
    mis_cnt_d    = mis_cnt_q;
    first_vld_d  = first_vld_q;
    first_idx_d  = first_idx_q;

    if (load_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end

    case (state_q)
      IDLE:  if (start_acc) begin state_d = RUN; rd_ptr_d = '0; end
      RUN: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (last_issue) state_d = FLUSH;
      end
      FLUSH: if (!vld_p0_q && !vld_p1_q) state_d = DONE;
      DONE:  if (start_acc) begin state_d = RUN; rd_ptr_d = '0; end
      default: state_d = IDLE;
    endcase

    if (start_acc) begin
      mis_cnt_d   = '0;
      first_vld_d = 1'b0;
      first_idx_d = '0;
    end else if (mis) begin
      if (mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
      if (!first_vld_q) begin
        first_vld_d = 1'b1;
        first_idx_d = idx_p1_q;
      end
    end

    if (bus.clear) begin
      state_d      = IDLE;
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      vld_p0_d     = 1'b0;
      vld_p1_d     = 1'b0;
      dut_in_vec_d = '0;
      mis_cnt_d    = '0;
      first_vld_d  = 1'b0;
      first_idx_d  = '0;
    end

    // busy drops on the same edge that done rises.
    busy_d       = ((state_q == RUN) || (state_q == FLUSH)) && ((state_d == RUN) || (state_d == FLUSH));
    done_d       = (state_d == DONE);
    load_ready_d = (state_d == IDLE) && (count_d < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      idx_p0_q     <= '0;
      idx_p1_q     <= '0;
      dut_in_vec_q <= '0;
      mis_cnt_q    <= '0;
      first_vld_q  <= 1'b0;
      first_idx_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      idx_p0_q     <= idx_p0_d;
      idx_p1_q     <= idx_p1_d;
      dut_in_vec_q <= dut_in_vec_d;
      mis_cnt_q    <= mis_cnt_d;
      first_vld_q  <= first_vld_d;
      first_idx_q  <= first_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  // p0: buffer read; p1: expectation aligned with the vector on the L2 pins
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_in[wr_ptr_q]  <= bus.load_in_vec;
      mem_out[wr_ptr_q] <= bus.load_out_vec;
    end
    rd_in_p0_q  <= rd_in_p0_d;
    rd_out_p0_q <= rd_out_p0_d;
    exp_p1_q    <= rd_out_p0_q;
  end

  assign bus.load_ready      = load_ready_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.dut_in_vec      = dut_in_vec_q;
  assign bus.mismatch_cnt    = mis_cnt_q;
  assign bus.first_mis_valid = first_vld_q;
  assign bus.first_mis_idx   = first_idx_q;

endmodule

// File: tb/tb_l2_playback_replay.sv
// Randomized bench for l2_playback_replay: a queue-based model of the stored vector pairs and a
// loopback L2 response predict the per-cycle pins and the mismatch results.
module tb_l2_playback_replay;
  localparam int IN_W   = 170;
  localparam int OUT_W  = 71;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  l2_playback_replay_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  l2_playback_replay #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [OUT_W-1:0] l2_resp(input logic [IN_W-1:0] v);
    return v[70:0] ^ v[141:71] ^ {v[169:142], 43'd0};
  endfunction

  assign bus.dut_out_vec = l2_resp(bus.dut_in_vec);

  logic [IN_W-1:0]  m_in[$];
  logic [OUT_W-1:0] m_out[$];
  logic [OUT_W-1:0] m_mask[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_in();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] rand_out();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[OUT_W-1:0];
  endfunction

  function automatic bit entry_fails(input int k);
    logic [OUT_W-1:0] d;
    d = l2_resp(m_in[k]) ^ m_out[k];
`ifdef L2_PLAYBACK_MASK_EN
    d = d & m_mask[k];
`endif
    return |d;
  endfunction

  task automatic drive_entry(input logic [IN_W-1:0] vi, input logic [OUT_W-1:0] vo,
                             input logic [OUT_W-1:0] vm);
    bus.load_in_vec  = vi;
    bus.load_out_vec = vo;
`ifdef L2_PLAYBACK_MASK_EN
    bus.load_out_mask = vm;
`endif
  endtask

  // Engine is IDLE when called; acceptance follows from the model's fill level alone.
  task automatic load_one(input logic [IN_W-1:0] vi, input logic [OUT_W-1:0] vo,
                          input logic [OUT_W-1:0] vm);
    bit exp_rdy;
    exp_rdy = (m_in.size() < DEPTH);
    drive_entry(vi, vo, vm);
    bus.load_valid = 1'b1;
    @(negedge clk);
    chk("load_ready", 256'(bus.load_ready), 256'(exp_rdy));
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    if (exp_rdy) begin
      m_in.push_back(vi);
      m_out.push_back(vo);
      m_mask.push_back(vm);
    end
  endtask

  task automatic add_random(input int n, input int err_pct);
    logic [IN_W-1:0]  vi;
    logic [OUT_W-1:0] vo, vm;
    for (int i = 0; i < n; i++) begin
      vi = rand_in();
      vo = l2_resp(vi);
      vm = rand_out() | rand_out();
      if ($urandom_range(99) < err_pct) vo = vo ^ rand_out();
      load_one(vi, vo, vm);
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    m_in.delete();
    m_out.delete();
    m_mask.delete();
  endtask

  // Start a replay (optionally with a same-cycle load) and check every cycle until after done.
  task automatic run(input bit with_load, input logic [IN_W-1:0] vi,
                     input logic [OUT_W-1:0] vo, input logic [OUT_W-1:0] vm);
    int n, cnt, fidx;
    bit fvld;
    bit fails[$];
    logic [IN_W-1:0] exp_in;
    if (with_load) begin
      drive_entry(vi, vo, vm);
      bus.load_valid = 1'b1;
      m_in.push_back(vi);
      m_out.push_back(vo);
      m_mask.push_back(vm);
    end
    n = m_in.size();
    fails.delete();
    for (int k = 0; k < n; k++) fails.push_back(entry_fails(k));
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.load_valid = 1'b0;
    for (int j = 0; j <= n + 4; j++) begin
      @(negedge clk);
      exp_in = (j >= 2 && j - 2 < n) ? m_in[j-2] : '0;
      cnt = 0; fvld = 1'b0; fidx = 0;
      for (int k = 0; k < n && k + 3 <= j; k++)
        if (fails[k]) begin
          if (!fvld) fidx = k;
          fvld = 1'b1;
          cnt++;
        end
      chk($sformatf("dut_in_vec@%0d", j), 256'(bus.dut_in_vec), 256'(exp_in));
      chk($sformatf("busy@%0d", j), 256'(bus.busy), 256'(j >= 1 && j < n + 3));
      chk($sformatf("done@%0d", j), 256'(bus.done), 256'(j >= n + 3));
      chk($sformatf("load_ready@%0d", j), 256'(bus.load_ready), 256'(0));
      chk($sformatf("mismatch_cnt@%0d", j), 256'(bus.mismatch_cnt), 256'(cnt));
      chk($sformatf("first_mis_valid@%0d", j), 256'(bus.first_mis_valid), 256'(fvld));
      chk($sformatf("first_mis_idx@%0d", j), 256'(bus.first_mis_idx), 256'(fidx));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [IN_W-1:0]  vi;
    logic [OUT_W-1:0] vo, b5;
    bus.clear = 1'b0; bus.load_valid = 1'b0; bus.start = 1'b0;
    drive_entry('0, '0, '0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst load_ready", 256'(bus.load_ready), 256'(1));
    chk("rst busy", 256'(bus.busy), 256'(0));
    chk("rst done", 256'(bus.done), 256'(0));
    chk("rst dut_in_vec", 256'(bus.dut_in_vec), 256'(0));
    chk("rst mismatch_cnt", 256'(bus.mismatch_cnt), 256'(0));
    chk("rst first_mis_valid", 256'(bus.first_mis_valid), 256'(0));
    chk("rst first_mis_idx", 256'(bus.first_mis_idx), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean loopback of 4 entries.
    add_random(4, 0);
    run(0, '0, '0, '0);

    // Entry 2 expectation bit 0 flipped; then replay again from DONE.
    do_clear();
    for (int i = 0; i < 4; i++) begin
      vi = rand_in();
      vo = l2_resp(vi);
      if (i == 2) vo[0] = ~vo[0];
      load_one(vi, vo, '1);
    end
    run(0, '0, '0, '0);
    chk("flip mismatch_cnt", 256'(bus.mismatch_cnt), 256'(1));
    chk("flip first_mis_idx", 256'(bus.first_mis_idx), 256'(2));
    run(0, '0, '0, '0);

    // Randomized runs with random expectation corruption.
    for (int r = 0; r < 4; r++) begin
      do_clear();
      add_random(int'($urandom_range(1, 20)), 40);
      run(0, '0, '0, '0);
    end

    // start with an empty buffer is ignored.
    do_clear();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty busy", 256'(bus.busy), 256'(0));
      chk("empty done", 256'(bus.done), 256'(0));
      chk("empty load_ready", 256'(bus.load_ready), 256'(1));
    end
    @(posedge clk);
    #1;

    // Same-cycle load + start on an empty buffer: one-entry replay.
    vi = rand_in();
    run(1, vi, l2_resp(vi) ^ 71'd8, '1);

    // Fill to capacity, attempt an extra load, replay all 256.
    do_clear();
    add_random(DEPTH, 5);
    add_random(1, 0);
    chk("full count", 256'(m_in.size()), 256'(DEPTH));
    run(0, '0, '0, '0);

    // Asynchronous reset in the middle of an 8-entry run.
    do_clear();
    add_random(8, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre-abort dut_in_vec", 256'(bus.dut_in_vec), 256'(m_in[0]));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort dut_in_vec", 256'(bus.dut_in_vec), 256'(0));
    chk("abort busy", 256'(bus.busy), 256'(0));
    chk("abort load_ready", 256'(bus.load_ready), 256'(1));
    chk("abort done", 256'(bus.done), 256'(0));
    m_in.delete(); m_out.delete(); m_mask.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-abort busy", 256'(bus.busy), 256'(0));
      chk("post-abort done", 256'(bus.done), 256'(0));
    end
    @(posedge clk);
    #1;

    // Expectation differs only in bit 5, which the mask excludes.
    add_random(1, 0);
    b5 = '0;
    b5[5] = 1'b1;
    vi = rand_in();
    load_one(vi, l2_resp(vi) ^ b5, ~b5);
    run(0, '0, '0, '0);
`ifdef L2_PLAYBACK_MASK_EN
    chk("mask mismatch_cnt", 256'(bus.mismatch_cnt), 256'(0));
`else
    chk("mask mismatch_cnt", 256'(bus.mismatch_cnt), 256'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/l2_playback_replay.md
# l2_playback_replay

Synthesizable vector-replay engine for the L2 tile in the manycore playback flow. It sits directly downstream of the L2 stimulus dump: it holds the captured input/output vector pairs in an on-block buffer. It replays each 170-bit input vector onto the L2 input pins one per clock and compares the 71-bit L2 output vector against the stored expectation. It reports the mismatch count and the first failing index.

## Interface
Parameters:
- IN_W, 170, width of the L2 input vector (rst_n down to rtap_srams_bist_data)
- OUT_W, 71, width of the L2 output vector (noc1_ready_in down to srams_rtap_data)
- DEPTH, 256, number of vector-pair entries
- ADDR_W, 8, log2(DEPTH)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush: empty buffer, clear results, go IDLE
- load_valid  in  1  load handshake valid
- load_ready  out  1  load handshake ready
- load_in_vec  in  IN_W  stimulus vector to store
- load_out_vec  in  OUT_W  expected output vector to store
- load_out_mask  in  OUT_W  per-bit compare enable (only with L2_PLAYBACK_MASK_EN)
- start  in  1  begin replay of entries 0..count-1
- busy  out  1  replay in progress
- done  out  1  replay finished, results stable
- dut_in_vec  out  IN_W  driven to the L2 inputs
- dut_out_vec  in  OUT_W  sampled from the L2 outputs
- mismatch_cnt  out  16  compares that failed, saturating
- first_mis_valid  out  1  at least one mismatch seen
- first_mis_idx  out  ADDR_W  entry index of the first mismatch

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset → IDLE.
- IDLE:
  - load_ready = (count < DEPTH).
  - A load_valid & load_ready edge writes the entry at wr_ptr; wr_ptr and count increment.
  - When count == DEPTH, load_ready = 0 and no wrap occurs.
- IDLE + start + count > 0 → RUN, rd_ptr = 0. start is ignored when count == 0 and in RUN/FLUSH.
- Simultaneous load and start in IDLE: the load is accepted first, and the replay includes the new entry.
- RUN: issues one read per cycle at rd_ptr++. When rd_ptr reaches count−1 and issues, go to FLUSH.
- FLUSH: wait until the final compare retires, then go to DONE.
- DONE: start replays again from entry 0 and clears the results; the buffer is kept. clear → IDLE.
- clear in any state: state = IDLE, count, wr_ptr, rd_ptr, mismatch_cnt, first_mis_* = 0. clear beats start and load in the same cycle.
- Compare: mismatch when (dut_out_vec ^ exp) has any set bit.
  - On a mismatch, mismatch_cnt increments and saturates at 16'hFFFF.
  - On the first mismatch, first_mis_idx is latched and first_mis_valid is set.
- dut_in_vec = 0 outside the replay window. Bit IN_W−1 is the L2 rst_n, so the L2 is held in reset while idle.
- Buffer contents are not reset. rst_n clears count, so the buffer reads as empty.

## Timing
- Reset values: load_ready = 1, busy = 0, done = 0, dut_in_vec = 0, mismatch_cnt = 0, first_mis_valid = 0, first_mis_idx = 0.
- Buffer read is synchronous, with 1 cycle latency.
- dut_in_vec and the aligned expected register are flops.
- start is accepted at edge E0. Vector k is driven from edge E0+2+k through E0+3+k. dut_out_vec is compared against out_vec[k] at edge E0+3+k.
- busy is high from E0+1 through the last compare edge.
- done rises at edge E0+3+N for an N-entry run and stays high until start or clear.
- mismatch_cnt is updated on the compare edge, visible 0 cycles after that edge.
- An asynchronous rst_n mid-run aborts immediately: all outputs return to their reset values.

## Configuration
- L2_PLAYBACK_MASK_EN defined:
  - Each entry also stores load_out_mask.
  - The compare uses (dut_out_vec ^ exp) & mask; masked bits never fail.
- Not defined:
  - The load_out_mask port is absent.
  - All OUT_W bits are compared, and no mask storage is built.

## Test plan
- Load 4 entries with out_vec equal to the actual DUT response (loopback model), start → dut_in_vec shows entries 0..3 at E0+2..E0+5; done at E0+7; mismatch_cnt = 0, first_mis_valid = 0.
- Loopback with entry 2 expectation bit 0 flipped → mismatch_cnt = 1, first_mis_idx = 2, first_mis_valid = 1.
- Load 256 entries → load_ready = 0 after the 256th. A 257th load_valid is not accepted, and count stays 256.
- start with count = 0 → stays IDLE, busy = 0. Simultaneous load_valid + start in IDLE with count = 0 → 1-entry replay, done at E0+4.
- Deassert rst_n at E0+3 of an 8-entry run → dut_in_vec = 0, busy = 0, load_ready = 1 asynchronously. After reset, start is ignored because count = 0.
- With L2_PLAYBACK_MASK_EN: entry 1 mask bit 5 = 0 and the expectation differs only in bit 5 → mismatch_cnt = 0. Without the macro, the same expectation gives mismatch_cnt = 1.
